// File: rtl/role_pr_quiesce_ctrl_if.sv
// Snooped role-to-static AXI handshake bundle for the PR quiesce controller.
// master: drives the address/response handshake bits; slave: observes them.
interface role_pr_quiesce_ctrl_if;
    logic AW_VALID;
    logic AW_READY;
    logic AR_VALID;
    logic AR_READY;
    logic B_VALID;
    logic B_READY;
    logic R_VALID;
    logic R_READY;
    logic R_LAST;

    modport master (
        output AW_VALID, AW_READY, AR_VALID, AR_READY,
        output B_VALID, B_READY, R_VALID, R_READY, R_LAST
    );

    modport slave (
        input AW_VALID, AW_READY, AR_VALID, AR_READY,
        input B_VALID, B_READY, R_VALID, R_READY, R_LAST
    );
endinterface

// File: rtl/role_pr_quiesce_ctrl.sv
// Quiesces a reconfigurable role before partial reconfiguration: drains
// outstanding AXI bursts, isolates and resets the role, launches PR, then
// holds reset before releasing the role.
// Ports: CLK_IN_250/AXI_RESET clock and sync reset; PR_REQ/PR_DONE/PR_ERROR
// PR control; axi snooped handshakes; BLOCK_NEW/DECOUPLE/ROLE_RESET/PR_START
// controls; STATE, sticky TIMEOUT_ERR/CNT_ERR, WR_OUTST/RD_OUTST counts.
module role_pr_quiesce_ctrl #(
    parameter int CNT_W         = 6,
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int RST_HOLD      = 16
) (
    input  logic                 CLK_IN_250,
    input  logic                 AXI_RESET,
    input  logic                 PR_REQ,
    input  logic                 PR_DONE,
    input  logic                 PR_ERROR,
    role_pr_quiesce_ctrl_if.slave axi,
    output logic                 BLOCK_NEW,
    output logic                 DECOUPLE,
    output logic                 ROLE_RESET,
    output logic                 PR_START,
    output logic [2:0]           STATE,
    output logic                 TIMEOUT_ERR,
    output logic                 CNT_ERR,
    output logic [CNT_W-1:0]     WR_OUTST,
    output logic [CNT_W-1:0]     RD_OUTST
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        ISOLATE = 3'd2,
        WAIT_PR = 3'd3,
        HOLD    = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]  wr_d, rd_d;
    logic              wr_e, rd_e;
    logic              tmo_hit;
    logic              forced;
    logic              blk_d, dec_d, rr_d, st_d;

    wire aw_hs = axi.AW_VALID & axi.AW_READY;
    wire ar_hs = axi.AR_VALID & axi.AR_READY;
    wire b_hs  = axi.B_VALID & axi.B_READY;
    wire r_hs  = axi.R_VALID & axi.R_READY & axi.R_LAST;

    // Saturating burst counters; a simultaneous up/down cancels out.
    always_comb begin
        wr_d = WR_OUTST;
        wr_e = 1'b0;
        rd_d = RD_OUTST;
        rd_e = 1'b0;
        if (aw_hs && !b_hs) begin
            if (WR_OUTST == CMAX) wr_e = 1'b1;
            else wr_d = WR_OUTST + 1'b1;
        end else if (b_hs && !aw_hs) begin
            if (WR_OUTST == '0) wr_e = 1'b1;
            else wr_d = WR_OUTST - 1'b1;
        end
        if (ar_hs && !r_hs) begin
            if (RD_OUTST == CMAX) rd_e = 1'b1;
            else rd_d = RD_OUTST + 1'b1;
        end else if (r_hs && !ar_hs) begin
            if (RD_OUTST == '0) rd_e = 1'b1;
            else rd_d = RD_OUTST - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        tmo_d   = '0;
        hold_d  = '0;
        case (state_q)
            RUN: begin
                if (PR_REQ) state_d = DRAIN;
            end
            DRAIN: begin
                tmo_d = tmo_q + 1'b1;
                if (WR_OUTST == '0 && RD_OUTST == '0) begin
                    state_d = ISOLATE;
                end else if (tmo_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    state_d = ISOLATE;
                    tmo_hit = 1'b1;
                end
            end
            ISOLATE: state_d = WAIT_PR;
            WAIT_PR: begin
                if (PR_ERROR) state_d = FAULT;
                else if (PR_DONE) state_d = HOLD;
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(RST_HOLD - 1)) state_d = RUN;
            end
            FAULT: begin
                if (PR_REQ) state_d = ISOLATE;
            end
            default: state_d = RUN;
        endcase
    end

    // Counters read as zero whenever the role is isolated.
    always_comb begin
        forced = (state_d != RUN) && (state_d != DRAIN);
        blk_d  = (state_d != RUN);
        dec_d  = forced;
        rr_d   = forced;
        st_d   = (state_d == ISOLATE);
    end

    always_ff @(posedge CLK_IN_250) begin
        if (AXI_RESET) begin
            state_q     <= RUN;
            tmo_q       <= '0;
            hold_q      <= '0;
            WR_OUTST    <= '0;
            RD_OUTST    <= '0;
            TIMEOUT_ERR <= 1'b0;
            CNT_ERR     <= 1'b0;
            BLOCK_NEW   <= 1'b0;
            DECOUPLE    <= 1'b0;
            ROLE_RESET  <= 1'b0;
            PR_START    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            WR_OUTST    <= forced ? '0 : wr_d;
            RD_OUTST    <= forced ? '0 : rd_d;
            TIMEOUT_ERR <= TIMEOUT_ERR | tmo_hit;
            CNT_ERR     <= CNT_ERR | ((wr_e | rd_e) & ~forced);
            BLOCK_NEW   <= blk_d;
            DECOUPLE    <= dec_d;
            ROLE_RESET  <= rr_d;
            PR_START    <= st_d;
        end
    end

    assign STATE = state_q;
endmodule
